// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions used by the read/write channel blocks.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        RESP_E_OKAY   = 2'b00,
        RESP_E_EXOKAY = 2'b01,
        RESP_E_SLVERR = 2'b10,
        RESP_E_DECERR = 2'b11
    } axil_resp_e;

    // Anything other than a plain OKAY counts as an error for data masking.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/axil_rdata_buf_if.sv
// Signal bundle between the memory return / R channel and the read-data buffer.
interface axil_rdata_buf_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  MREADY;
    logic [DATA_WIDTH-1:0] MDATA;
    logic [1:0]            MRESP;
    logic                  MFULL;
    logic                  OVERFLOW;
    logic [CNT_W-1:0]      RCOUNT;
    logic                  RVALID;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RREADY;

    modport slave (
        input  MREADY, MDATA, MRESP, RREADY,
        output MFULL, OVERFLOW, RCOUNT, RVALID, RDATA, RRESP
    );

    modport master (
        output MREADY, MDATA, MRESP, RREADY,
        input  MFULL, OVERFLOW, RCOUNT, RVALID, RDATA, RRESP
    );

endinterface

// File: rtl/axil_sync_fifo.sv
// Generic first-word-fall-through FIFO with a registered head word.
// Callers must qualify push_i with !full_o and pop_i with !empty_o.
module axil_sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] occ_after_pop;
    logic [WIDTH-1:0] head_q, head_d;

    // The head register is loaded with whatever entry will sit at the read
    // pointer next cycle; it holds its value while the FIFO is empty.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        head_d        = head_q;
        occ_after_pop = count_q;

        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_i) begin
            rd_ptr_d      = rd_ptr_q + PTR_W'(1);
            occ_after_pop = count_q - CNT_W'(1);
        end

        if (push_i && !pop_i) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - CNT_W'(1);
        end

        // Surviving entries are already in storage; otherwise the incoming word becomes head.
        if (occ_after_pop != '0) begin
            head_d = mem_q[rd_ptr_d];
        end else if (push_i) begin
            head_d = wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = head_q;
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/axil_rdata_buf.sv
// AXI4-Lite slave R channel: buffers memory read returns so the master may stall RREADY.
module axil_rdata_buf #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int ZERO_ON_ERR = 1,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input logic             clk,
    input logic             resetn,
    axil_rdata_buf_if.slave bus
);
    import axil_pkg::*;

    localparam int BEAT_W = DATA_WIDTH + 2;

    logic                  push;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [DATA_WIDTH-1:0] wdata_masked;
    logic [BEAT_W-1:0]     wbeat;
    logic [BEAT_W-1:0]     head;
    logic [CNT_W-1:0]      count;
    logic                  overflow_q, overflow_d;

    always_comb begin
        wdata_masked = bus.MDATA;
        if ((ZERO_ON_ERR != 0) && resp_is_err(bus.MRESP)) begin
            wdata_masked = '0;
        end
    end

    assign wbeat = {bus.MRESP, wdata_masked};

    // Full is decoded from the stored count only, so a beat arriving while
    // full is dropped even if the master pops in the same cycle.
    assign push       = bus.MREADY && !full;
    assign pop        = !empty && bus.RREADY;
    assign overflow_d = overflow_q || (bus.MREADY && full);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    axil_sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (resetn),
        .push_i  (push),
        .wdata_i (wbeat),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (count),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.MFULL    = full;
    assign bus.OVERFLOW = overflow_q;
    assign bus.RCOUNT   = count;
    assign bus.RVALID   = !empty;
    assign bus.RDATA    = head[DATA_WIDTH-1:0];
    assign bus.RRESP    = head[BEAT_W-1 -: 2];

endmodule
